// File: rtl/prbs_tx_if.sv
// Control and data bundle for the PRBS9 transmitter.
// The master side drives the controls, the slave side (the transmitter) drives the bit stream.
interface prbs_tx_if #(
   parameter int RATE_W = 8
);
   logic              i_enable;
   logic              i_load;
   logic [8:0]        i_seed;
   logic [RATE_W-1:0] i_rate;
   logic              i_inject;
   logic [15:0]       i_err_period;
   logic              o_bit;
   logic              o_ref;
   logic              o_valid;
   logic [63:0]       o_bits_sent;
   logic [63:0]       o_errors_injected;

   modport master (
      output i_enable, i_load, i_seed, i_rate, i_inject, i_err_period,
      input  o_bit, o_ref, o_valid, o_bits_sent, o_errors_injected
   );

   modport slave (
      input  i_enable, i_load, i_seed, i_rate, i_inject, i_err_period,
      output o_bit, o_ref, o_valid, o_bits_sent, o_errors_injected
   );
endinterface

// File: rtl/prbs_tx.sv
// PRBS9 (x^9+x^5+1) bit-stream transmitter with rate divider and error injection.
// o_ref carries the clean sequence, o_bit the possibly-corrupted copy.
module prbs_tx #(
   parameter logic [8:0] SEED   = 9'h1FF,
   parameter int         RATE_W = 8
) (
   input logic          clock,
   input logic          i_reset,
   prbs_tx_if.slave     bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // An all-zero SEED would lock the LFSR, so fall back to the all-ones state.
   localparam logic [8:0] SEED_NZ = (SEED == 9'd0) ? 9'h1FF : SEED;

   state_t            state_q, state_d;
   logic [8:0]        lfsr_q, lfsr_d;
   logic [RATE_W-1:0] div_q, div_d;
   logic [15:0]       per_q, per_d;
   logic              pend_q, pend_d;
   logic              bit_q, bit_d;
   logic              ref_q, ref_d;
   logic              valid_q, valid_d;
   logic [63:0]       sent_q, sent_d;
   logic [63:0]       errs_q, errs_d;

   logic strobe, emit, periodic, flip;

   always_comb begin
      strobe   = (state_q == RUN) && (div_q == bus.i_rate);
      emit     = strobe && !bus.i_load;
      periodic = (bus.i_err_period != 16'd0) && (per_q == bus.i_err_period - 16'd1);
      flip     = pend_q | periodic;

      state_d = bus.i_enable ? RUN : IDLE;
      lfsr_d  = lfsr_q;
      per_d   = per_q;
      bit_d   = bit_q;
      ref_d   = ref_q;
      valid_d = 1'b0;
      sent_d  = sent_q;
      errs_d  = errs_q;
      pend_d  = pend_q | bus.i_inject;

      if (state_q == RUN) begin
         div_d = strobe ? '0 : div_q + RATE_W'(1);
      end else begin
         div_d = '0;
      end

      if (emit) begin
         lfsr_d  = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
         ref_d   = lfsr_q[8];
         bit_d   = lfsr_q[8] ^ flip;
         valid_d = 1'b1;
         sent_d  = sent_q + 64'd1;
         if (flip) begin
            errs_d = errs_q + 64'd1;
         end
         per_d  = periodic ? 16'd0 : per_q + 16'd1;
         // A request arriving while the old one is consumed targets the next bit.
         pend_d = bus.i_inject;
      end

      if (bus.i_err_period == 16'd0) begin
         per_d = 16'd0;
      end

      if (bus.i_load) begin
         lfsr_d = (bus.i_seed == 9'd0) ? SEED_NZ : bus.i_seed;
         div_d  = '0;
         per_d  = 16'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_NZ;
         div_q   <= '0;
         per_q   <= 16'd0;
         pend_q  <= 1'b0;
         bit_q   <= 1'b0;
         ref_q   <= 1'b0;
         valid_q <= 1'b0;
         sent_q  <= 64'd0;
         errs_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         div_q   <= div_d;
         per_q   <= per_d;
         pend_q  <= pend_d;
         bit_q   <= bit_d;
         ref_q   <= ref_d;
         valid_q <= valid_d;
         sent_q  <= sent_d;
         errs_q  <= errs_d;
      end
   end

   assign bus.o_bit             = bit_q;
   assign bus.o_ref             = ref_q;
   assign bus.o_valid           = valid_q;
   assign bus.o_bits_sent       = sent_q;
   assign bus.o_errors_injected = errs_q;
endmodule

// File: tb/tb_prbs_tx.sv
// Directed bench for prbs_tx: sequence shape, rate divider, injection, seed load, reset.
module tb_prbs_tx;
   logic clock = 1'b0;
   logic i_reset;
   int   checks = 0;
   int   errors = 0;
   int   gaps;
   logic ref_a [0:1023];
   logic bit_a [0:1023];

   prbs_tx_if #(.RATE_W(8)) bus ();

   prbs_tx #(.SEED(9'h1FF), .RATE_W(8)) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      i_reset      = 1'b0;
      bus.i_load   = 1'b0;
      bus.i_inject = 1'b0;
      tick();
      tick();
      i_reset = 1'b1;
   endtask

   // Gathers n valid bits; gaps counts idle cycles between the first and last of them.
   task automatic collect(input int n);
      int got = 0;
      int budget = n * 8 + 40;
      gaps = 0;
      while (got < n && budget > 0) begin
         tick();
         budget--;
         if (bus.o_valid) begin
            ref_a[got] = bus.o_ref;
            bit_a[got] = bus.o_bit;
            got++;
         end else if (got > 0) begin
            gaps++;
         end
      end
      check("collect_count", 64'(got), 64'(n));
   endtask

   function automatic logic [15:0] pack_ref(input int start, input int n);
      logic [15:0] w = '0;
      for (int i = 0; i < n; i++) w = (w << 1) | 16'(ref_a[start + i]);
      return w;
   endfunction

   function automatic logic [15:0] pack_diff(input int start, input int n);
      logic [15:0] w = '0;
      for (int i = 0; i < n; i++) w = (w << 1) | 16'(ref_a[start + i] ^ bit_a[start + i]);
      return w;
   endfunction

   initial begin
      int ones, rep_bad, diff_bad, diff_cnt, pos_bad, vcnt;
      logic v39, v40;

      i_reset          = 1'b0;
      bus.i_enable     = 1'b0;
      bus.i_load       = 1'b0;
      bus.i_seed       = 9'd0;
      bus.i_rate       = 8'd0;
      bus.i_inject     = 1'b0;
      bus.i_err_period = 16'd0;

      // Reset state
      do_reset();
      check("rst_valid", 64'(bus.o_valid), 64'd0);
      check("rst_bit", 64'(bus.o_bit), 64'd0);
      check("rst_ref", 64'(bus.o_ref), 64'd0);
      check("rst_sent", bus.o_bits_sent, 64'd0);
      check("rst_errs", bus.o_errors_injected, 64'd0);

      // Full-rate run over two periods
      bus.i_enable = 1'b1;
      collect(1022);
      check("seq_1_10", 64'(pack_ref(0, 10)), 64'h3FE);
      check("seq_11_20", 64'(pack_ref(10, 10)), 64'h03D);
      ones = 0; rep_bad = 0; diff_bad = 0;
      for (int i = 0; i < 511; i++) begin
         ones += int'(ref_a[i]);
         if (ref_a[i] !== ref_a[i + 511]) rep_bad++;
      end
      for (int i = 0; i < 1022; i++) if (ref_a[i] !== bit_a[i]) diff_bad++;
      check("ones_per_period", 64'(ones), 64'd256);
      check("period_repeat", 64'(rep_bad), 64'd0);
      check("bit_eq_ref", 64'(diff_bad), 64'd0);
      check("rate0_gaps", 64'(gaps), 64'd0);
      check("rate0_sent", bus.o_bits_sent, 64'd1022);
      check("rate0_errs", bus.o_errors_injected, 64'd0);

      // Divider at i_rate=3
      bus.i_enable = 1'b0;
      do_reset();
      bus.i_rate   = 8'd3;
      bus.i_enable = 1'b1;
      tick();
      vcnt = 0; v39 = 1'b0; v40 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         vcnt += int'(bus.o_valid);
         if (k == 39) v39 = bus.o_valid;
         if (k == 40) v40 = bus.o_valid;
      end
      check("rate3_valids", 64'(vcnt), 64'd10);
      check("rate3_v39", 64'(v39), 64'd0);
      check("rate3_v40", 64'(v40), 64'd1);
      check("rate3_sent", bus.o_bits_sent, 64'd10);

      // Periodic injection every 100 bits
      bus.i_enable = 1'b0;
      do_reset();
      bus.i_rate       = 8'd0;
      bus.i_err_period = 16'd100;
      bus.i_enable     = 1'b1;
      collect(1000);
      diff_cnt = 0; pos_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         if (ref_a[i] !== bit_a[i]) diff_cnt++;
         if ((ref_a[i] !== bit_a[i]) != ((i + 1) % 100 == 0)) pos_bad++;
      end
      check("per_diff_cnt", 64'(diff_cnt), 64'd10);
      check("per_positions", 64'(pos_bad), 64'd0);
      check("per_errs", bus.o_errors_injected, 64'd10);
      check("per_sent", bus.o_bits_sent, 64'd1000);

      // Inject while idle hits the first emitted bit only
      bus.i_enable     = 1'b0;
      bus.i_err_period = 16'd0;
      do_reset();
      bus.i_inject = 1'b1;
      tick();
      bus.i_inject = 1'b0;
      tick();
      bus.i_enable = 1'b1;
      collect(5);
      check("idle_inj_bit1", 64'(bit_a[0]), 64'd0);
      check("idle_inj_ref1", 64'(ref_a[0]), 64'd1);
      check("idle_inj_diff", 64'(pack_diff(0, 5)), 64'h10);
      check("idle_inj_errs", bus.o_errors_injected, 64'd1);

      // Pending inject coinciding with periodic flip
      bus.i_enable = 1'b0;
      do_reset();
      bus.i_rate       = 8'd3;
      bus.i_err_period = 16'd2;
      bus.i_enable     = 1'b1;
      collect(1);
      check("coin_bit1_clean", 64'(pack_diff(0, 1)), 64'd0);
      bus.i_inject = 1'b1;
      tick();
      bus.i_inject = 1'b0;
      collect(1);
      check("coin_bit2_flip", 64'(pack_diff(0, 1)), 64'd1);
      check("coin_errs_once", bus.o_errors_injected, 64'd1);
      collect(2);
      check("coin_bits34", 64'(pack_diff(0, 2)), 64'h1);
      check("coin_errs_end", bus.o_errors_injected, 64'd2);

      // Seed load
      bus.i_enable = 1'b0;
      do_reset();
      bus.i_rate       = 8'd0;
      bus.i_err_period = 16'd0;
      bus.i_enable     = 1'b1;
      collect(20);
      bus.i_load = 1'b1;
      bus.i_seed = 9'd0;
      tick();
      bus.i_load = 1'b0;
      check("load_suppress", 64'(bus.o_valid), 64'd0);
      collect(10);
      check("load0_seq", 64'(pack_ref(0, 10)), 64'h3FE);
      bus.i_load = 1'b1;
      bus.i_seed = 9'h001;
      tick();
      bus.i_load = 1'b0;
      collect(9);
      check("load1_seq", 64'(pack_ref(0, 9)), 64'h001);

      // Reset mid-run
      bus.i_enable = 1'b0;
      do_reset();
      bus.i_enable = 1'b1;
      collect(300);
      check("mid_sent", bus.o_bits_sent, 64'd300);
      i_reset = 1'b0;
      tick();
      check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
      check("mid_rst_sent", bus.o_bits_sent, 64'd0);
      check("mid_rst_errs", bus.o_errors_injected, 64'd0);
      i_reset = 1'b1;
      tick();
      check("mid_idle", 64'(bus.o_valid), 64'd0);
      collect(10);
      check("mid_restart_seq", 64'(pack_ref(0, 10)), 64'h3FE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
